instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port read_address  output  32  byte address to instruction memory, driven directly from PC register.
REQ-006 SHALL have port instruction_in  input  32  instruction memory data, combinational from read_address in same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port id_valid  output  1  decode-side entry available.
REQ-010 SHALL have port id_ready  input  1  decode accepts entry when id_valid and id_ready are both high.
REQ-011 SHALL have port id_instr  output  32  head-entry instruction.
REQ-012 SHALL have port id_pc  output  32  head-entry PC.
REQ-013 SHALL have port fetch_fault  output  1  sticky fault flag, fetch halted.

Function
REQ-014 SHALL hold a 2-entry FIFO of {pc, instr} pairs; id_valid = (count != 0); id_instr/id_pc = head entry, 0 when empty.
REQ-015 SHALL push {PC, instruction_in} at rising edge and advance PC by 4 when: no redirect, fetch_fault low, and (count < 2 or a pop occurs in the same cycle).
REQ-016 SHALL pop the head entry at rising edge when id_valid and id_ready.
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged and preserve entry order.
REQ-018 SHALL, when count == 2 and no pop, hold PC and perform no push; read_address stays stable.
REQ-019 SHALL, on redirect_valid, at the same edge: empty FIFO (count <= 0), load PC <= redirect_pc, clear fetch_fault, suppress push and pop.
REQ-020 SHALL give redirect priority over push, pop, and fault setting in the same cycle.
REQ-021 SHALL set fetch_fault, with no push, when PC >= IMEM_WORDS*4 at a would-be push; fetching stays halted until redirect or reset, FIFO still drains.
REQ-022 SHALL compute PC + 4 modulo 2^32; wrap from 32'hFFFF_FFFC to 0 without error.
REQ-023 SHALL give a first-instruction latency of one cycle: entry visible on id_pc/id_instr the cycle after its PC appears on read_address.
REQ-024 SHALL keep FIFO pointers 1 bit wide and count 2 bits wide; count SHALL never exceed 2.

Reset
REQ-025 SHALL, on reset, set PC=RESET_PC, count=0, pointers=0, fetch_fault=0; id_valid=0, id_instr=0, id_pc=0.
REQ-026 SHALL give reset priority over redirect and all other activity, including mid-stream with a full FIFO.
REQ-027 SHALL clear all FIFO entry storage to 0 on reset.

Configuration
REQ-028 SHALL use macro FETCH_MISALIGN_TRAP_EN to control handling of misaligned redirect targets.
REQ-029 SHALL, with FETCH_MISALIGN_TRAP_EN defined and redirect_pc[1:0] != 0, load PC, empty the FIFO, and set fetch_fault at the redirect edge, halting fetch.
REQ-030 SHALL, without FETCH_MISALIGN_TRAP_EN, force redirect_pc[1:0] to 2'b00 on load and never set fault for misalignment.

Verification
REQ-031 SHALL cover: reset, then id_ready=1 and memory words 0..3 = 32'h11,22,33,44 -> id_pc 0,4,8,C with matching instr on consecutive cycles, starting one cycle after reset release.
REQ-032 SHALL cover: id_ready=0 for 5 cycles -> count saturates at 2 (pc 0,4), read_address holds 8; id_ready=1 -> pops pc 0, then 4, then 8 in order.
REQ-033 SHALL cover: FIFO full, redirect_valid with redirect_pc=32'h40 asserted together with id_ready -> next cycle id_valid=0 and read_address=40; following cycle id_pc=40.
REQ-034 SHALL cover: IMEM_WORDS=4, free run -> pushes pc 0..C, then fetch_fault=1 with read_address=10; redirect to 0 clears the fault.
REQ-035 SHALL cover: redirect_pc=32'h22 -> with macro, fetch_fault=1 and no pushes; without macro, read_address=20 and normal fetch.
REQ-036 SHALL cover: reset asserted with FIFO full and redirect_valid high -> next cycle id_valid=0, read_address=RESET_PC, fetch_fault=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register feeding a 2-entry {pc, instr} FIFO toward decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise fetch_fault instead of being word-aligned.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] read_address,
    input  logic [31:0] instruction_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] ent_pc_q    [2];
    logic [31:0] ent_instr_q [2];

    logic        pop, fetch_try, oob, push;
    logic [31:0] redir_pc;
    logic        redir_fault;

    always_comb begin
        pop       = id_valid && id_ready && !redirect_valid;
        // a full FIFO can still accept when the head leaves this same cycle
        fetch_try = !redirect_valid && !fault_q && ((cnt_q != 2'd2) || pop);
        oob       = {1'b0, pc_q} >= PC_LIMIT;
        push      = fetch_try && !oob;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_comb begin
        redir_pc    = redirect_pc;
        redir_fault = |redirect_pc[1:0];
    end
`else
    always_comb begin
        redir_pc    = {redirect_pc[31:2], 2'b00};
        redir_fault = 1'b0;
    end
`endif

    always_comb begin
        pc_d     = pc_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            pc_d     = redir_pc;
            fault_d  = redir_fault;
            cnt_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (fetch_try && oob) fault_d = 1'b1;
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ent_pc_q[i]    <= 32'd0;
                ent_instr_q[i] <= 32'd0;
            end
        end else begin
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                ent_pc_q[wr_ptr_q]    <= pc_q;
                ent_instr_q[wr_ptr_q] <= instruction_in;
            end
        end
    end

    always_comb begin
        read_address = pc_q;
        fetch_fault  = fault_q;
        id_valid     = (cnt_q != 2'd0);
        id_pc        = id_valid ? ent_pc_q[rd_ptr_q]    : 32'd0;
        id_instr     = id_valid ? ent_instr_q[rd_ptr_q] : 32'd0;
    end

endmodule
